rs_keysched_seq: RTL and testbench

// - Sequential, area-reduced Twofish RS key-schedule engine: derives S-box key words S0/S1 from a 128-bit key.
// - Serialises the RS(8x4) GF(2^8) matrix product over 16 cycles using 4 shared GF multipliers (one per matrix row).
// - Sits between the key-load interface and the g-function S-box key inputs; valid/ready on both sides.

---
 rtl/rs_keysched_seq.sv | 163 ++++++++++++++++
 tb/tb_rs_keysched_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_keysched_seq.sv
// Sequential Twofish RS key-schedule engine: 16 steps, 4 shared GF(2^8) multipliers.
// Optional abort input enabled by defining RS_ABORT_EN.
module rs_keysched_seq #(
  parameter logic [8:0] GF_POLY = 9'h14D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  s0,
  output logic [31:0]  s1,
  output logic         busy
`ifdef RS_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     key_q, key_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      s0_q, s0_d;
  logic [31:0]      s1_q, s1_d;
  logic [127:0]     key_sh_s;
  logic [7:0]       cur_byte_s;
  logic [31:0]      acc_upd_s;
  logic             abort_s;

`ifdef RS_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      if (x[7]) x = (x << 1) ^ GF_POLY[7:0];
      else      x = x << 1;
    end
    return p;
  endfunction

  // Row r of the RS matrix, column c selected by shifting the row's bytes to the top.
  function automatic logic [7:0] rs_coef(input logic [1:0] r, input logic [2:0] c);
    logic [63:0] row;
    case (r)
      2'd0:    row = 64'h01A4_5587_5A58_DB9E;
      2'd1:    row = 64'hA456_82F3_1EC6_68E5;
      2'd2:    row = 64'h02A1_FCC1_47AE_3D19;
      2'd3:    row = 64'hA455_875A_58DB_9E03;
      default: row = 64'h0000_0000_0000_0000;
    endcase
    row = row << {c, 3'b000};
    return row[63:56];
  endfunction

  // One matrix column per step: byte m[cnt] times column cnt[2:0] of every row.
  always_comb begin
    key_sh_s   = key_q << {cnt_q, 3'b000};
    cur_byte_s = key_sh_s[127:120];
    acc_upd_s[7:0]   = acc_q[7:0]   ^ gf_mul(rs_coef(2'd0, cnt_q[2:0]), cur_byte_s);
    acc_upd_s[15:8]  = acc_q[15:8]  ^ gf_mul(rs_coef(2'd1, cnt_q[2:0]), cur_byte_s);
    acc_upd_s[23:16] = acc_q[23:16] ^ gf_mul(rs_coef(2'd2, cnt_q[2:0]), cur_byte_s);
    acc_upd_s[31:24] = acc_q[31:24] ^ gf_mul(rs_coef(2'd3, cnt_q[2:0]), cur_byte_s);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    acc_d   = acc_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_d   = key;
          acc_d   = 32'h0000_0000;
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          acc_d   = 32'h0000_0000;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd15) begin
          s0_d    = acc_upd_s;
          acc_d   = 32'h0000_0000;
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else if (cnt_q == 4'd7) begin
          // First half complete: publish S1 early, restart accumulation for S0.
          s1_d    = acc_upd_s;
          acc_d   = 32'h0000_0000;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          acc_d   = acc_upd_s;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (abort_s || out_ready) begin
          acc_d   = 32'h0000_0000;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        acc_d   = 32'h0000_0000;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      key_q   <= 128'h0;
      acc_q   <= 32'h0000_0000;
      s0_q    <= 32'h0000_0000;
      s1_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      acc_q   <= acc_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign s0        = s0_q;
  assign s1        = s1_q;

endmodule

// File: tb/tb_rs_keysched_seq.sv
// Randomised self-checking bench for rs_keysched_seq against a cycle-level reference model.
module tb_rs_keysched_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  s0;
  logic [31:0]  s1;
  logic         busy;
  logic         abort_in;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int          m_run_left;
  bit          m_done;
  logic [31:0] m_s0, m_s1, p_s0, p_s1;

  int rs_mat [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  rs_keysched_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy)
`ifdef RS_ABORT_EN
    ,
    .abort     (abort_in)
`endif
  );

  always #5 clk = ~clk;

  // Carry-less product followed by long division by the field polynomial.
  function automatic int gf_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--)
      if ((p >> i) & 1) p = p ^ (32'h14D << (i - 8));
    return p & 8'hFF;
  endfunction

  function automatic logic [63:0] rs_ref(input logic [127:0] k);
    int m [16];
    int acc;
    logic [31:0] sx [2];
    for (int j = 0; j < 16; j++) m[j] = int'(k[127 - 8*j -: 8]);
    for (int h = 0; h < 2; h++) begin
      sx[h] = 32'h0;
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int c = 0; c < 8; c++) acc = acc ^ gf_ref(rs_mat[r][c], m[8*h + c]);
        sx[h][8*r +: 8] = acc[7:0];
      end
    end
    return {sx[1], sx[0]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Spec-level model: a countdown of remaining steps and a result-held flag.
  always @(posedge clk) begin
    logic [63:0] r;
    if (rst) begin
      m_run_left = 0; m_done = 1'b0; m_s0 = 32'h0; m_s1 = 32'h0;
    end else if (m_run_left > 0) begin
      if (abort_in) m_run_left = 0;
      else begin
        m_run_left = m_run_left - 1;
        if (m_run_left == 8) m_s1 = p_s1;
        if (m_run_left == 0) begin m_s0 = p_s0; m_done = 1'b1; end
      end
    end else if (m_done) begin
      if (abort_in || out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      r = rs_ref(key);
      p_s0 = r[63:32]; p_s1 = r[31:0];
      m_run_left = 16;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  in_ready,  (m_run_left == 0) && !m_done);
      chk("busy",      busy,      m_run_left > 0);
      chk("out_valid", out_valid, m_done);
      chk("s0",        s0,        m_s0);
      chk("s1",        s1,        m_s1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a key, optionally push junk keys during RUN, hold the result, then release it.
  task automatic run_key(input logic [127:0] k, input int hold, input bit junk,
                         output logic [31:0] got_s0, output logic [31:0] got_s1);
    int t, hs;
    t = 0;
    while (!in_ready && t < 100) begin step(1); t++; end
    chk("ready_timeout", t < 100, 1'b1);
    in_valid = 1'b1; key = k;
    step(1);
    hs = cyc;
    in_valid = junk; key = ~k;
    if (junk) begin step(3); in_valid = 1'b0; end
    t = 0;
    while (!out_valid && t < 40) begin step(1); t++; end
    // DONE starts 16 edges after the handshake edge (cycle N+17).
    chk("latency", cyc - hs, 16);
    got_s0 = s0; got_s1 = s1;
    repeat (hold) begin
      step(1);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_s1", s1, got_s1);
      chk("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] g0, g1;
    rst = 1'b1; in_valid = 1'b0; key = 128'h0; out_ready = 1'b0; abort_in = 1'b0;
    step(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s0s1", {s0, s1}, 64'h0);

    r = rs_ref(128'h01 << 120); chk("ref_m0", r, 64'h0000_0000_A402_A401);
    r = rs_ref(128'h01 << 56);  chk("ref_m8", r, 64'hA402_A401_0000_0000);
    r = rs_ref(128'h01 << 64);  chk("ref_m7_s1", r[31:0], 32'h0319_E59E);

    run_key(128'h0, 0, 1'b0, g0, g1);        chk("zero_key", {g0, g1}, 64'h0);
    run_key(128'h01 << 120, 0, 1'b0, g0, g1); chk("m0_key", {g0, g1}, 64'h0000_0000_A402_A401);
    run_key(128'h01 << 56, 0, 1'b0, g0, g1);  chk("m8_key", {g0, g1}, 64'hA402_A401_0000_0000);
    run_key(128'h01 << 64, 10, 1'b1, g0, g1); chk("m7_key", g1, 32'h0319_E59E);

    // Reset while cnt==5.
    in_valid = 1'b1; key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    step(1);
    in_valid = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_s", {s0, s1}, 64'h0);
    run_key(128'h01 << 120, 2, 1'b0, g0, g1); chk("after_rst", {g0, g1}, 64'h0000_0000_A402_A401);

`ifdef RS_ABORT_EN
    in_valid = 1'b1; key = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    step(1);
    in_valid = 1'b0;
    step(9);
    abort_in = 1'b1;
    step(1);
    abort_in = 1'b0;
    chk("abort_ready", in_ready, 1'b1);
    step(20);
    chk("abort_no_valid", out_valid, 1'b0);
`endif

    for (int i = 0; i < 25000; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      key       = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) key = 128'hFF << (8 * $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) == 0);
`ifdef RS_ABORT_EN
      abort_in  = ($urandom_range(0, 99) == 0);
`endif
      rst       = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort_in = 1'b0;
    step(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
